// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the always-on domain: issues POR/SW/WDT resets, holds them for a
// minimum width and confirms release through the synchronized acknowledge fed back downstream.
module rst_seq_ctrl #(
  parameter int HOLD_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES  = 32,
  parameter int ACK_SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW_RST_REQ,
  input  logic       WDT_RST_REQ,
  input  logic       RST_ACK,
  output logic       RST_OUT_N,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [1:0] RST_CAUSE
);

  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ASSERT  = 2'b01,
    RELEASE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_SW  = 2'b01,
    CAUSE_WDT = 2'b10
  } cause_e;

  state_e                     state_q, state_d;
  logic   [CNT_W-1:0]         cnt_q, cnt_d;
  cause_e                     cause_q, cause_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;
  logic                       rst_out_n_q;
  logic                       busy_q;
  logic [ACK_SYNC_STAGES-1:0] ack_sync_q;
  logic                       ack_s;

  // RST_ACK is asynchronous to CLK; a plain flop chain resynchronizes it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[ACK_SYNC_STAGES-2:0], RST_ACK};
    end
  end

  assign ack_s = ack_sync_q[ACK_SYNC_STAGES-1];

  // NOTE: every variable gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (WDT_RST_REQ) begin
          state_d = ASSERT;
          cause_d = CAUSE_WDT;
        end else if (SW_RST_REQ) begin
          state_d = ASSERT;
          cause_d = CAUSE_SW;
        end
      end

      ASSERT: begin
        // Saturate at the hold limit; a stuck-high acknowledge stretches the reset here.
        if (cnt_q == HOLD_LAST) begin
          if (!ack_s) begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        // Unreachable encoding: recover by resetting the downstream domains.
        state_d = ASSERT;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    if ((state_d == ASSERT) && (state_q != ASSERT)) begin
      err_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ASSERT;
      cnt_q       <= '0;
      cause_q     <= CAUSE_POR;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      rst_out_n_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      err_q       <= err_d;
      done_q      <= done_d;
      rst_out_n_q <= (state_d != ASSERT);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign RST_OUT_N = rst_out_n_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign RST_CAUSE = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: a 5-stage downstream synchronizer model closes the acknowledge
// loop on the default instance; a second instance covers the minimum-parameter corner.
module tb_rst_seq_ctrl;

  localparam int HOLD       = 16;
  localparam int TIMEOUT    = 32;
  localparam int ACK_STAGES = 2;
  localparam int N_SYNC     = 5;
  // ack_s rises N_SYNC+ACK_STAGES cycles after release; the FSM exits on the following edge.
  localparam int DONE_LAT   = N_SYNC + ACK_STAGES + 1;
  localparam int BOUND      = 200;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       sw_req  = 1'b0;
  logic       wdt_req = 1'b0;
  logic       rst_ack;
  logic       rst_out_n, busy, done, err;
  logic [1:0] rst_cause;
  logic [1:0] ack_mode = 2'd0;  // 0: synchronizer model, 1: tied high, 2: tied low
  logic [N_SYNC-1:0] sync_q = '0;

  logic       rst2_n  = 1'b0;
  logic       sw2_req = 1'b0;
  logic       rst_out_n2, busy2, done2, err2;
  logic [1:0] rst_cause2;
  int         cnt2_max = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Downstream domain synchronizer, asynchronously reset by the sequencer output.
  always @(posedge clk or negedge rst_out_n) begin
    if (!rst_out_n) sync_q <= '0;
    else            sync_q <= {sync_q[N_SYNC-2:0], 1'b1};
  end

  assign rst_ack = (ack_mode == 2'd0) ? sync_q[N_SYNC-1] : (ack_mode == 2'd1);

  rst_seq_ctrl #(
    .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT), .ACK_SYNC_STAGES(ACK_STAGES)
  ) u_dut (
    .CLK(clk), .RST(rst_n), .SW_RST_REQ(sw_req), .WDT_RST_REQ(wdt_req), .RST_ACK(rst_ack),
    .RST_OUT_N(rst_out_n), .BUSY(busy), .DONE(done), .ERR(err), .RST_CAUSE(rst_cause)
  );

  rst_seq_ctrl #(
    .HOLD_CYCLES(2), .TIMEOUT_CYCLES(2), .ACK_SYNC_STAGES(2)
  ) u_dut2 (
    .CLK(clk), .RST(rst2_n), .SW_RST_REQ(sw2_req), .WDT_RST_REQ(1'b0), .RST_ACK(1'b0),
    .RST_OUT_N(rst_out_n2), .BUSY(busy2), .DONE(done2), .ERR(err2), .RST_CAUSE(rst_cause2)
  );

  always @(posedge clk) begin
    if (int'(u_dut2.cnt_q) > cnt2_max) cnt2_max <= int'(u_dut2.cnt_q);
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  // Counts sampled cycles with the reset output low, starting at the current negedge.
  task automatic measure_low(input bit which, output int n);
    n = 0;
    while (((which ? rst_out_n2 : rst_out_n) == 1'b0) && (n < BOUND)) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Counts edges from the current negedge until DONE is seen.
  task automatic measure_done(input bit which, output int n);
    n = 0;
    while (((which ? done2 : done) == 1'b0) && (n < BOUND)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic start_req(input bit sw, input bit wdt);
    sw_req  = sw;
    wdt_req = wdt;
    @(negedge clk);
    sw_req  = 1'b0;
    wdt_req = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rst_out_n, busy, done, err, rst_cause} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_state got %b expected %b", {rst_out_n, busy, done, err, rst_cause}, 6'b010000);
    end
    rst_n = 1'b1;
    measure_low(1'b0, n);
    checks++;
    if (n != HOLD) begin
      errors++;
      $display("FAIL por_low_cycles got %0d expected %0d", n, HOLD);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL por_busy_release got %b expected 1", busy);
    end
    measure_done(1'b0, n);
    checks++;
    if (n != DONE_LAT) begin
      errors++;
      $display("FAIL por_done_latency got %0d expected %0d", n, DONE_LAT);
    end
    checks++;
    if ({busy, err, rst_cause} !== 4'b0000) begin
      errors++;
      $display("FAIL por_end_state got %b expected 0000", {busy, err, rst_cause});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL por_done_single got %b expected 0", done);
    end
  endtask

  task automatic test_sw();
    int n;
    start_req(1'b1, 1'b0);
    checks++;
    if ({rst_out_n, busy, rst_cause} !== 4'b0101) begin
      errors++;
      $display("FAIL sw_start got %b expected 0101", {rst_out_n, busy, rst_cause});
    end
    measure_low(1'b0, n);
    checks++;
    if (n != HOLD) begin
      errors++;
      $display("FAIL sw_low_cycles got %0d expected %0d", n, HOLD);
    end
    measure_done(1'b0, n);
    checks++;
    if (n != DONE_LAT || err !== 1'b0) begin
      errors++;
      $display("FAIL sw_done got lat=%0d err=%b expected lat=%0d err=0", n, err, DONE_LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    bit idle_bad;
    start_req(1'b1, 1'b1);
    checks++;
    if ({rst_out_n, rst_cause} !== 3'b010) begin
      errors++;
      $display("FAIL both_req_cause got %b expected 010", {rst_out_n, rst_cause});
    end
    n = 0;
    while (rst_out_n == 1'b0 && n < BOUND) begin
      sw_req = (n == 5);
      n++;
      @(negedge clk);
    end
    sw_req = 1'b0;
    checks++;
    if (n != HOLD) begin
      errors++;
      $display("FAIL ignore_assert_low got %0d expected %0d", n, HOLD);
    end
    n = 0;
    while (done == 1'b0 && n < BOUND) begin
      sw_req = (n == 3);
      @(negedge clk);
      n++;
    end
    sw_req = 1'b0;
    checks++;
    if (n != DONE_LAT || rst_cause !== 2'b10) begin
      errors++;
      $display("FAIL ignore_release got lat=%0d cause=%b expected lat=%0d cause=10", n, rst_cause, DONE_LAT);
    end
    idle_bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!rst_out_n || done || busy) idle_bad = 1'b1;
    end
    checks++;
    if (idle_bad) begin
      errors++;
      $display("FAIL no_extra_sequence got activity expected idle");
    end
  endtask

  task automatic test_stuck_ack();
    int n;
    ack_mode = 2'd1;
    start_req(1'b1, 1'b0);
    repeat (40) @(negedge clk);
    checks++;
    if ({rst_out_n, busy} !== 2'b01 || u_dut.cnt_q !== 6'(HOLD - 1)) begin
      errors++;
      $display("FAIL stretch got rst_out_n=%b busy=%b cnt=%0d expected 0 1 %0d", rst_out_n, busy, u_dut.cnt_q, HOLD - 1);
    end
    ack_mode = 2'd0;
    measure_low(1'b0, n);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL stretch_exit got %0d expected 3", n);
    end
    measure_done(1'b0, n);
    @(negedge clk);

    ack_mode = 2'd2;
    start_req(1'b1, 1'b0);
    measure_low(1'b0, n);
    measure_done(1'b0, n);
    checks++;
    if (n != TIMEOUT || {err, busy, rst_cause} !== 4'b1001) begin
      errors++;
      $display("FAIL timeout got lat=%0d err/busy/cause=%b expected %0d 1001", n, {err, busy, rst_cause}, TIMEOUT);
    end
    ack_mode = 2'd0;
    repeat (10) @(negedge clk);
    checks++;
    if ({err, done} !== 2'b10) begin
      errors++;
      $display("FAIL err_sticky got err/done=%b expected 10", {err, done});
    end
    start_req(1'b1, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b expected 0", err);
    end
    measure_low(1'b0, n);
    measure_done(1'b0, n);
    checks++;
    if (n != DONE_LAT || err !== 1'b0) begin
      errors++;
      $display("FAIL recover_done got lat=%0d err=%b expected %0d 0", n, err, DONE_LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_release();
    int n;
    start_req(1'b0, 1'b1);
    measure_low(1'b0, n);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rst_out_n, busy, done, rst_cause} !== 5'b01000) begin
      errors++;
      $display("FAIL mid_reset got %b expected 01000", {rst_out_n, busy, done, rst_cause});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    measure_low(1'b0, n);
    checks++;
    if (n != HOLD) begin
      errors++;
      $display("FAIL repor_low got %0d expected %0d", n, HOLD);
    end
    measure_done(1'b0, n);
    checks++;
    if (n != DONE_LAT || rst_cause !== 2'b00) begin
      errors++;
      $display("FAIL repor_done got lat=%0d cause=%b expected %0d 00", n, rst_cause, DONE_LAT);
    end
  endtask

  task automatic test_sweep();
    int n;
    rst2_n = 1'b1;
    measure_low(1'b1, n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL min_por_low got %0d expected 2", n);
    end
    measure_done(1'b1, n);
    checks++;
    if (n != 2 || err2 !== 1'b1) begin
      errors++;
      $display("FAIL min_timeout got lat=%0d err=%b expected 2 1", n, err2);
    end
    @(negedge clk);
    sw2_req = 1'b1;
    @(negedge clk);
    sw2_req = 1'b0;
    checks++;
    if ({err2, rst_cause2} !== 3'b001) begin
      errors++;
      $display("FAIL min_sw_start got %b expected 001", {err2, rst_cause2});
    end
    measure_low(1'b1, n);
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL min_sw_low got %0d expected 2", n);
    end
    measure_done(1'b1, n);
    checks++;
    if (n != 2 || err2 !== 1'b1) begin
      errors++;
      $display("FAIL min_sw_timeout got lat=%0d err=%b expected 2 1", n, err2);
    end
    @(negedge clk);
    checks++;
    if (cnt2_max != 1) begin
      errors++;
      $display("FAIL min_cnt_limit got %0d expected 1", cnt2_max);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_back_to_back();
    test_stuck_ack();
    test_reset_mid_release();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer that generates the active-low asynchronous reset consumed by the per-domain reset synchronizers. It produces power-on, software and watchdog resets, holds each for a minimum pulse width, and then confirms release through an acknowledge fed back from the downstream synchronized reset. It sits in the always-on clock domain, upstream of every domain reset synchronizer.

## Interface
- HOLD_CYCLES, 16, minimum number of CLK cycles RST_OUT_N is held low; legal range ≥ 2.
- TIMEOUT_CYCLES, 32, maximum number of cycles to wait for the release acknowledge; legal range ≥ 2.
- ACK_SYNC_STAGES, 2, flop stages on RST_ACK; legal range ≥ 2.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- SW_RST_REQ  in  1  software reset request, synchronous to CLK, single-cycle pulse.
- WDT_RST_REQ  in  1  watchdog reset request, synchronous to CLK, single-cycle pulse.
- RST_ACK  in  1  asynchronous feedback from the downstream synchronizer output; 1 = domain out of reset.
- RST_OUT_N  out  1  registered active-low reset to the downstream synchronizers.
- BUSY  out  1  high while the sequencer is in ASSERT or RELEASE.
- DONE  out  1  one-cycle pulse when a sequence ends.
- ERR  out  1  sticky flag; set on acknowledge timeout.
- RST_CAUSE  out  2  cause of the last sequence: 00 POR, 01 SW, 10 WDT.

## Operation
- RST_ACK passes through an ACK_SYNC_STAGES flop chain, reset to 0. The chain output is ack_s.
- Counter cnt has width $clog2(max(HOLD_CYCLES,TIMEOUT_CYCLES)+1) and is unsigned. It resets to 0 on every state entry.
- States:
  - IDLE: RST_OUT_N=1, BUSY=0.
    - If WDT_RST_REQ=1, go to ASSERT with RST_CAUSE=10.
    - Otherwise, if SW_RST_REQ=1, go to ASSERT with RST_CAUSE=01.
    - Both requests together: WDT wins.
  - ASSERT: RST_OUT_N=0, BUSY=1.
    - cnt increments and saturates at HOLD_CYCLES-1.
    - Go to RELEASE when cnt==HOLD_CYCLES-1 and ack_s==0.
    - While ack_s stays 1, remain in ASSERT (stretched reset).
  - RELEASE: RST_OUT_N=1, BUSY=1.
    - If ack_s==1, go to IDLE and pulse DONE.
    - Otherwise, if cnt==TIMEOUT_CYCLES-1, go to IDLE, pulse DONE and set ERR=1.
    - Otherwise, cnt increments.
- Entering ASSERT clears ERR.
- SW_RST_REQ and WDT_RST_REQ are ignored outside IDLE; they are not queued.
- Reset values:
  - state = ASSERT, cnt = 0, ack chain = 0.
  - RST_OUT_N = 0, BUSY = 1, DONE = 0, ERR = 0, RST_CAUSE = 00.
  - This makes the first sequence after power-on automatic, with cause POR.
- RST asserted mid-sequence: all registers return to their reset values immediately. RST_OUT_N drops asynchronously, and the POR sequence restarts after RST deasserts.

## Timing
- Request sampled at IDLE edge E0: after E0, RST_OUT_N=0, BUSY=1 and RST_CAUSE is updated.
- With ack_s already 0 at the end of hold, RST_OUT_N is low for exactly HOLD_CYCLES cycles and rises after edge E0+HOLD_CYCLES.
- After RST deasserts, RST_OUT_N stays low for HOLD_CYCLES CLK edges, counted from the first edge (minimum).
- RELEASE exit: DONE is high for the one cycle after the exit edge. BUSY falls on the same edge.
- Acknowledge latency through a downstream N-stage synchronizer on CLK is N + ACK_SYNC_STAGES cycles from the RST_OUT_N rise.
- Timeout: with ack_s held 0, ERR and DONE assert TIMEOUT_CYCLES cycles after entering RELEASE.
- All outputs are registered and glitch-free. RST_OUT_N has no combinational path from any input.

## Test plan
- POR, with bench model of a 5-stage synchronizer feeding RST_ACK:
  - RST low for 3 cycles, then high.
  - RST_OUT_N=0 for 16 edges, then 1.
  - ack_s rises 7 cycles later.
  - DONE pulses once. RST_CAUSE=00, ERR=0, BUSY=0 afterwards.
- SW request in IDLE: 1-cycle SW_RST_REQ pulse.
  - RST_OUT_N low exactly 16 cycles, RST_CAUSE=01.
  - DONE pulses about 7 cycles after release.
- Simultaneous SW_RST_REQ and WDT_RST_REQ in IDLE: RST_CAUSE=10, single sequence.
  - Repeat SW pulses during ASSERT/RELEASE: ignored, no extra sequence.
- Stuck acknowledge:
  - RST_ACK tied 1: the sequencer stays in ASSERT indefinitely with RST_OUT_N=0.
  - RST_ACK tied 0: RELEASE times out after 32 cycles; ERR=1, DONE pulses.
  - A following SW request clears ERR.
- RST asserted mid-RELEASE: RST_OUT_N goes 0 immediately, RST_CAUSE returns to 00, and the full POR sequence repeats.
- Parameter sweep HOLD_CYCLES=2, TIMEOUT_CYCLES=2:
  - RST_OUT_N low exactly 2 cycles.
  - Timeout after 2 cycles with RST_ACK=0.
  - Counter never exceeds its limit.
